// File: rtl/sha256_hk_pkg.sv
// Shared types and constants for the SHA-256 H/K constant fetch sequencer.
package sha256_hk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_FETCH_H  = 3'd2,
        ST_FETCH_K  = 3'd3,
        ST_FIN      = 3'd4
    } hk_state_e;

    localparam int unsigned H_WORDS = 8;
    localparam int unsigned K_WORDS = 64;

    // Element 0 is H0 and lands in the most significant word.
    localparam logic [0:7][31:0] H_FIPS = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] K_FIRST = 32'h428a2f98;
    localparam logic [31:0] K_LAST  = 32'hc67178f2;

    function automatic logic [31:0] h_fips_word(input logic [2:0] idx);
        return H_FIPS[idx];
    endfunction

endpackage

// File: rtl/sha256_hk_fetch_if.sv
// Memory-side and consumer-side signals of the H/K fetch sequencer.
interface sha256_hk_fetch_if;
    logic         start;
    logic         mem_rdy;
    logic         hk_selector;
    logic [2:0]   h_addr;
    logic [5:0]   k_addr;
    logic [31:0]  ram_dr;
    logic [255:0] h_init;
    logic         h_done;
    logic [31:0]  k_t;
    logic [5:0]   k_idx;
    logic         k_valid;
    logic         k_ready;
    logic         busy;
    logic         done;
    logic         err;

    modport slave (
        input  start, mem_rdy, ram_dr, k_ready,
        output hk_selector, h_addr, k_addr, h_init, h_done,
               k_t, k_idx, k_valid, busy, done, err
    );

    modport master (
        output start, mem_rdy, ram_dr, k_ready,
        input  hk_selector, h_addr, k_addr, h_init, h_done,
               k_t, k_idx, k_valid, busy, done, err
    );
endinterface

// File: rtl/sha256_hk_check.sv
// Compares captured constants against the FIPS 180-4 values; ERR is sticky until reset.
module sha256_hk_check
    import sha256_hk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_cap_i,
    input  logic [2:0]  h_idx_i,
    input  logic        k_cap_i,
    input  logic [5:0]  k_idx_i,
    input  logic [31:0] data_i,
    output logic        err_o
);
    logic err_q;
    logic err_d;
    logic mismatch_s;

    // Mismatch detection for the word being captured this cycle
    always_comb begin
        mismatch_s = 1'b0;
        if (h_cap_i) begin
            mismatch_s = (data_i != h_fips_word(h_idx_i));
        end else if (k_cap_i && (k_idx_i == 6'd0)) begin
            mismatch_s = (data_i != K_FIRST);
        end else if (k_cap_i && (k_idx_i == 6'd63)) begin
            mismatch_s = (data_i != K_LAST);
        end else begin
            mismatch_s = 1'b0;
        end
        err_d = err_q | mismatch_s;
    end

    // Sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
endmodule

// File: rtl/sha256_hk_fetch.sv
// Fetches H0..H7 into a parallel register, then streams K0..K63 over valid/ready.
// Optional constant checking is enabled with the HK_FETCH_CHECK_EN macro.
module sha256_hk_fetch
    import sha256_hk_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    sha256_hk_fetch_if.slave bus
);
    hk_state_e        state_q, state_d;
    logic             hk_sel_q, hk_sel_d;
    logic [2:0]       h_addr_q, h_addr_d;
    logic [5:0]       k_addr_q, k_addr_d;
    logic [0:7][31:0] h_init_q, h_init_d;
    logic             h_done_q, h_done_d;
    logic [31:0]      k_t_q, k_t_d;
    logic [5:0]       k_idx_q, k_idx_d;
    logic             k_valid_q, k_valid_d;
    logic             k_pend_q, k_pend_d;
    logic             done_q, done_d;

    logic slot_free_s, k_hshk_s, abort_s, enter_h_s, h_cap_s, k_cap_s;

    assign slot_free_s = !k_valid_q || bus.k_ready;
    assign k_hshk_s    = k_valid_q && bus.k_ready;
    assign abort_s     = ((state_q == ST_FETCH_H) || (state_q == ST_FETCH_K)) && !bus.mem_rdy;
    assign enter_h_s   = (state_d == ST_FETCH_H) && (state_q != ST_FETCH_H);
    assign h_cap_s     = (state_q == ST_FETCH_H) && bus.mem_rdy;
    assign k_cap_s     = (state_q == ST_FETCH_K) && bus.mem_rdy && slot_free_s && k_pend_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (bus.start) begin
                    state_d = bus.mem_rdy ? ST_FETCH_H : ST_WAIT_MEM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rdy) begin
                    state_d = ST_FETCH_H;
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_FETCH_H: begin
                if (!bus.mem_rdy) begin
                    state_d = ST_WAIT_MEM;
                end else if (h_addr_q == 3'd7) begin
                    state_d = ST_FETCH_K;
                end else begin
                    state_d = ST_FETCH_H;
                end
            end
            ST_FETCH_K: begin
                if (!bus.mem_rdy) begin
                    state_d = ST_WAIT_MEM;
                end else if (k_hshk_s && (k_idx_q == 6'd63)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_FETCH_K;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        hk_sel_d  = hk_sel_q;
        h_addr_d  = h_addr_q;
        k_addr_d  = k_addr_q;
        h_init_d  = h_init_q;
        h_done_d  = h_done_q;
        k_t_d     = k_t_q;
        k_idx_d   = k_idx_q;
        k_valid_d = k_valid_q;
        k_pend_d  = k_pend_q;
        done_d    = done_q;
        if (enter_h_s) begin
            hk_sel_d = 1'b0;
            h_addr_d = 3'd0;
            h_done_d = 1'b0;
            done_d   = 1'b0;
        end else if (abort_s) begin
            k_valid_d = 1'b0;
            k_pend_d  = 1'b0;
            h_done_d  = 1'b0;
            done_d    = 1'b0;
        end else if (h_cap_s) begin
            h_init_d[h_addr_q] = bus.ram_dr;
            h_addr_d           = h_addr_q + 3'd1;
            if (h_addr_q == 3'd7) begin
                h_done_d = 1'b1;
                hk_sel_d = 1'b1;
                k_addr_d = 6'd0;
                k_pend_d = 1'b1;
            end else begin
                h_done_d = 1'b0;
            end
        end else if (k_cap_s) begin
            k_t_d     = bus.ram_dr;
            k_idx_d   = k_addr_q;
            k_valid_d = 1'b1;
            k_addr_d  = k_addr_q + 6'd1;
            k_pend_d  = (k_addr_q != 6'd63);
        end else if ((state_q == ST_FETCH_K) && slot_free_s) begin
            // Only reached once the last word has been captured: the slot drains.
            k_valid_d = 1'b0;
            if (k_hshk_s && (k_idx_q == 6'd63)) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            k_valid_d = k_valid_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hk_sel_q  <= 1'b0;
            h_addr_q  <= 3'd0;
            k_addr_q  <= 6'd0;
            h_init_q  <= '0;
            h_done_q  <= 1'b0;
            k_t_q     <= 32'd0;
            k_idx_q   <= 6'd0;
            k_valid_q <= 1'b0;
            k_pend_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hk_sel_q  <= hk_sel_d;
            h_addr_q  <= h_addr_d;
            k_addr_q  <= k_addr_d;
            h_init_q  <= h_init_d;
            h_done_q  <= h_done_d;
            k_t_q     <= k_t_d;
            k_idx_q   <= k_idx_d;
            k_valid_q <= k_valid_d;
            k_pend_q  <= k_pend_d;
            done_q    <= done_d;
        end
    end

    assign bus.hk_selector = hk_sel_q;
    assign bus.h_addr      = h_addr_q;
    assign bus.k_addr      = k_addr_q;
    assign bus.h_init      = h_init_q;
    assign bus.h_done      = h_done_q;
    assign bus.k_t         = k_t_q;
    assign bus.k_idx       = k_idx_q;
    assign bus.k_valid     = k_valid_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q == ST_WAIT_MEM) || (state_q == ST_FETCH_H) ||
                             (state_q == ST_FETCH_K);

`ifdef HK_FETCH_CHECK_EN
    sha256_hk_check u_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_cap_i (h_cap_s),
        .h_idx_i (h_addr_q),
        .k_cap_i (k_cap_s),
        .k_idx_i (k_addr_q),
        .data_i  (bus.ram_dr),
        .err_o   (bus.err)
    );
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_hk_fetch.sv
// Directed bench for sha256_hk_fetch with a FIPS-content constant memory model.
module tb_sha256_hk_fetch;
    logic clk;
    logic rst_n;
    sha256_hk_fetch_if bus ();

    sha256_hk_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] H_EXP = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] H_BAD = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'h00000000,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
`ifdef HK_FETCH_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic [31:0] hmem [8];
    logic [31:0] kmem [64];

    // Zero-latency constant memory
    always_comb bus.ram_dr = bus.hk_selector ? kmem[bus.k_addr] : hmem[bus.h_addr];

    typedef struct {
        int          edge_n;
        logic        sel;
        logic        h_done;
        logic        k_valid;
        logic [5:0]  k_idx;
        logic [31:0] k_t;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs [8];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.h_init, bus.h_done, bus.k_t, bus.k_idx, bus.k_valid, bus.busy,
                   bus.done, bus.err, bus.hk_selector, bus.h_addr, bus.k_addr}, 256'd0);
    endtask

    // Leaves the bench at the falling edge after the edge that sampled START.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edge);
        int e;
        e = 0;
        while (!bus.done && e < 300) begin
            @(negedge clk);
            e++;
        end
        chk(name, e, exp_edge);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          e;
    int          exp_idx;
    int          stalls;
    logic        prev_stall;
    logic [31:0] pk_t;
    logic [5:0]  pk_idx;
    logic [5:0]  ei;

    initial begin
        vecs[0] = '{0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,         1'b0, 1'b1};
        vecs[1] = '{7,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,         1'b0, 1'b1};
        vecs[2] = '{8,  1'b1, 1'b1, 1'b0, 6'd0,  32'h0,         1'b0, 1'b1};
        vecs[3] = '{9,  1'b1, 1'b1, 1'b1, 6'd0,  32'h428a2f98, 1'b0, 1'b1};
        vecs[4] = '{10, 1'b1, 1'b1, 1'b1, 6'd1,  32'h71374491, 1'b0, 1'b1};
        vecs[5] = '{40, 1'b1, 1'b1, 1'b1, 6'd31, 32'h14292967, 1'b0, 1'b1};
        vecs[6] = '{72, 1'b1, 1'b1, 1'b1, 6'd63, 32'hc67178f2, 1'b0, 1'b1};
        vecs[7] = '{73, 1'b1, 1'b1, 1'b0, 6'd0,  32'h0,         1'b1, 1'b0};
        for (int i = 0; i < 8; i++) hmem[i] = H_EXP[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) kmem[i] = K_TAB[i];

        bus.start = 1'b0; bus.mem_rdy = 1'b1; bus.k_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal run against the timing table; a stray START mid-run must be ignored.
        pulse_start();
        for (int ed = 0; ed <= 73; ed++) begin
            if (ed > 0) @(negedge clk);
            bus.start = (ed == 30);
            for (int v = 0; v < 8; v++) begin
                if (vecs[v].edge_n == ed) begin
                    chk($sformatf("tab%0d_sel", ed),     bus.hk_selector, vecs[v].sel);
                    chk($sformatf("tab%0d_h_done", ed),  bus.h_done,      vecs[v].h_done);
                    chk($sformatf("tab%0d_k_valid", ed), bus.k_valid,     vecs[v].k_valid);
                    chk($sformatf("tab%0d_done", ed),    bus.done,        vecs[v].done);
                    chk($sformatf("tab%0d_busy", ed),    bus.busy,        vecs[v].busy);
                    if (vecs[v].k_valid) begin
                        chk($sformatf("tab%0d_k_idx", ed), bus.k_idx, vecs[v].k_idx);
                        chk($sformatf("tab%0d_k_t", ed),   bus.k_t,   vecs[v].k_t);
                    end
                end
            end
            if (ed == 8) chk("nominal_h_init", bus.h_init, H_EXP);
        end
        chk("nominal_err", bus.err, 1'b0);

        // Memory not ready at START.
        do_reset();
        bus.mem_rdy = 1'b0;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("wait_busy", bus.busy, 1'b1);
        chk("wait_h_done", bus.h_done, 1'b0);
        repeat (10) @(negedge clk);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        chk("wait_entry_h_addr", bus.h_addr, 3'd0);
        chk("wait_entry_no_capture", bus.h_init[255:224], 32'd0);
        @(negedge clk);
        chk("wait_first_capture", bus.h_init[255:224], 32'h6a09e667);
        repeat (7) @(negedge clk);
        chk("wait_h_done_set", bus.h_done, 1'b1);
        chk("wait_h_init", bus.h_init, H_EXP);

        // Pseudo-random back-pressure.
        do_reset();
        pulse_start();
        exp_idx = 0; stalls = 0; prev_stall = 1'b0; e = 0;
        while (!bus.done && e < 400) begin
            if (prev_stall) begin
                chk("stall_k_valid", bus.k_valid, 1'b1);
                chk("stall_k_t", bus.k_t, pk_t);
                chk("stall_k_idx", bus.k_idx, pk_idx);
            end
            bus.k_ready = 1'($urandom_range(0, 1));
            if (bus.k_valid && bus.k_ready) begin
                ei = 6'(exp_idx);
                chk("bp_k_idx", bus.k_idx, ei);
                chk("bp_k_t", bus.k_t, K_TAB[ei]);
                exp_idx++;
            end
            prev_stall = bus.k_valid && !bus.k_ready;
            if (prev_stall) stalls++;
            pk_t = bus.k_t; pk_idx = bus.k_idx;
            @(negedge clk);
            e++;
        end
        chk("bp_word_count", exp_idx, 64);
        chk("bp_done_edge", e, 73 + stalls);
        bus.k_ready = 1'b1;

        // MEM_RDY drop at K_IDX=30, then full refetch.
        do_reset();
        pulse_start();
        e = 0;
        while (!(bus.k_valid && bus.k_idx == 6'd30) && e < 100) begin
            @(negedge clk);
            e++;
        end
        chk("abort_reach_edge", e, 39);
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        chk("abort_k_valid", bus.k_valid, 1'b0);
        chk("abort_h_done", bus.h_done, 1'b0);
        chk("abort_busy", bus.busy, 1'b1);
        repeat (3) @(negedge clk);
        chk("abort_hold_k_valid", bus.k_valid, 1'b0);
        chk("abort_hold_busy", bus.busy, 1'b1);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        chk("refetch_sel", bus.hk_selector, 1'b0);
        chk("refetch_h_addr", bus.h_addr, 3'd0);
        wait_done("refetch_done_edge", 73);
        chk("refetch_h_init", bus.h_init, H_EXP);

        // Asynchronous reset mid FETCH_K.
        do_reset();
        pulse_start();
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", bus.busy, 1'b0);
        pulse_start();
        wait_done("post_reset_done_edge", 73);
        chk("post_reset_h_init", bus.h_init, H_EXP);

        // Corrupted H3.
        do_reset();
        hmem[3] = 32'd0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("corrupt_err_before", bus.err, 1'b0);
        @(negedge clk);
        chk("corrupt_err_capture", bus.err, CHK_EN);
        wait_done("corrupt_done_edge", 69);
        chk("corrupt_err_at_done", bus.err, CHK_EN);
        chk("corrupt_h_init", bus.h_init, H_BAD);
        hmem[3] = H_EXP[159:128];

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
